dmem_responder: RTL

- Data-memory target for the core's dmem request interface (addr, ren, wen, mask, wdata); the pipeline is the initiator.
- Holds a word-organised SRAM array and executes byte-masked writes and full-word reads.
- Returns each response after a fixed, parameterised latency, so the pipeline and hazard logic can be exercised against a non-zero-latency memory.
- Handles one outstanding request at a time.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline (master) and the data-memory
// responder (slave); member names keep the responder-side direction prefixes.
interface dmem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [3:0]  i_req_mask;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_busy;

  modport master (
    output i_req_valid, i_req_addr, i_req_ren, i_req_wen, i_req_mask, i_req_wdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_ren, i_req_wen, i_req_mask, i_req_wdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-masked writes, answering one request
// at a time after a fixed LATENCY so the core sees a non-zero-latency memory.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  logic [29:0] r_word_addr;
  logic        r_ren;
  logic        r_wen;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_ready;
  logic          w_accept;
  logic          w_exec;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // Byte-offset bits never reach the array; only whole words are addressed.
  assign w_unused = ^bus.i_req_addr[1:0];

  assign w_ready  = (r_state == ST_IDLE) && i_rst;
  assign w_accept = bus.i_req_valid && w_ready;
  assign w_exec   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_idx    = r_word_addr[AW-1:0];
  assign w_err    = (r_ren && r_wen) || (r_word_addr[29:AW] != '0);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = 4'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_word_addr <= '0;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_mask      <= 4'd0;
      r_wdata     <= 32'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_word_addr <= bus.i_req_addr[31:2];
        r_ren       <= bus.i_req_ren;
        r_wen       <= bus.i_req_wen;
        r_mask      <= bus.i_req_mask;
        r_wdata     <= bus.i_req_wdata;
      end
      if (w_exec) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (r_ren && !w_err) ? r_mem[w_idx] : 32'd0;
      end
    end
  end

  // Array has no reset; an asserted reset forces IDLE, which blocks w_exec.
  always_ff @(posedge i_clk) begin
    if (w_exec && r_wen && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_rsp_valid = (r_state == ST_RESP);
  assign bus.o_rsp_rdata = r_rsp_rdata;
  assign bus.o_rsp_err   = r_rsp_err;

endmodule
